// File: rtl/txn_dequeue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : txn_dequeue                                                  |
// | Description : Write-side retirement for the AXI monitor. On each observed  |
// |               B handshake it finds the live head-tail entry for the B ID,  |
// |               frees the head linked-data slot, then advances the subqueue  |
// |               head or releases the entry. Also keeps the outstanding-write |
// |               count.                                                       |
// | Ports       : clk_i/rst_i         clock, async active-high reset           |
// |               b_*_i               observed B-channel handshake             |
// |               enq_done_i          enqueue committed this cycle             |
// |               ht_*_i, ld_*_i      flattened head-tail / linked-data tables |
// |               b_stall_o           gate upstream B ready while busy         |
// |               enq_inhibit_o       block enqueue while busy                 |
// |               ld_free_*, ht_*_o   table update strobes (POP cycle only)    |
// |               retired_budget_o    budget left on the retired entry         |
// |               late_resp_o         retired entry had zero budget            |
// |               unexpected_resp_o   B ID had no live subqueue                |
// |               overrun_o           sticky: handshake dropped / count error  |
// |               outstanding_o       outstanding write count                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module txn_dequeue #(
  parameter int MAX_WR_TXNS = 8,
  parameter int HT_CAPACITY = 8,
  parameter int ID_WIDTH    = 4,
  parameter int CNT_WIDTH   = 10,
  localparam int LD_IDX_W   = (MAX_WR_TXNS > 1) ? $clog2(MAX_WR_TXNS) : 1,
  localparam int HT_IDX_W   = (HT_CAPACITY > 1) ? $clog2(HT_CAPACITY) : 1,
  localparam int OUT_W      = $clog2(MAX_WR_TXNS + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            b_valid_i,
  input  logic                            b_ready_i,
  input  logic [ID_WIDTH-1:0]             b_id_i,
  input  logic                            enq_done_i,
  input  logic [HT_CAPACITY*ID_WIDTH-1:0] ht_id_i,
  input  logic [HT_CAPACITY*LD_IDX_W-1:0] ht_head_i,
  input  logic [HT_CAPACITY*LD_IDX_W-1:0] ht_tail_i,
  input  logic [HT_CAPACITY-1:0]          ht_free_i,
  input  logic [MAX_WR_TXNS*LD_IDX_W-1:0] ld_next_i,
  input  logic [MAX_WR_TXNS*CNT_WIDTH-1:0] ld_counter_i,
  output logic                            b_stall_o,
  output logic                            enq_inhibit_o,
  output logic                            ld_free_we_o,
  output logic [LD_IDX_W-1:0]             ld_free_idx_o,
  output logic                            ht_we_o,
  output logic [HT_IDX_W-1:0]             ht_idx_o,
  output logic                            ht_release_o,
  output logic [LD_IDX_W-1:0]             ht_new_head_o,
  output logic [CNT_WIDTH-1:0]            retired_budget_o,
  output logic                            late_resp_o,
  output logic                            unexpected_resp_o,
  output logic                            overrun_o,
  output logic [OUT_W-1:0]                outstanding_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_POP    = 2'd2;

  localparam logic [OUT_W-1:0] c_out_max = OUT_W'(MAX_WR_TXNS);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [HT_IDX_W-1:0]   r_ht_idx;
  logic [LD_IDX_W-1:0]   r_head;
  logic [LD_IDX_W-1:0]   r_tail;
  logic [LD_IDX_W-1:0]   r_next;
  logic [CNT_WIDTH-1:0]  r_counter;
  logic                  r_unexpected;
  logic                  r_overrun;
  logic [OUT_W-1:0]      r_outstanding;

  logic                  w_hs;
  logic                  w_pop;
  logic                  w_hit;
  logic [HT_IDX_W-1:0]   w_hit_idx;
  logic [LD_IDX_W-1:0]   w_hit_head;
  logic [LD_IDX_W-1:0]   w_hit_tail;

  assign w_hs  = b_valid_i & b_ready_i;
  assign w_pop = (r_state == S_POP);

  // Scan from the top down so the lowest matching index is the one left
  // standing; duplicates are illegal but must still resolve deterministically.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int k = HT_CAPACITY - 1; k >= 0; k--) begin
      if (!ht_free_i[k] && (ht_id_i[k*ID_WIDTH +: ID_WIDTH] == r_id)) begin
        w_hit     = 1'b1;
        w_hit_idx = HT_IDX_W'(k);
      end
    end
  end

  assign w_hit_head = ht_head_i[int'(w_hit_idx)*LD_IDX_W +: LD_IDX_W];
  assign w_hit_tail = ht_tail_i[int'(w_hit_idx)*LD_IDX_W +: LD_IDX_W];

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_hs) w_next_state = S_LOOKUP;
      S_LOOKUP: w_next_state = w_hit ? S_POP : S_IDLE;
      S_POP:    w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output logic: POP strobes come straight from the captured lookup result
  always_comb begin
    b_stall_o        = (r_state != S_IDLE);
    enq_inhibit_o    = (r_state != S_IDLE);
    ld_free_we_o     = 1'b0;
    ld_free_idx_o    = '0;
    ht_we_o          = 1'b0;
    ht_idx_o         = '0;
    ht_release_o     = 1'b0;
    ht_new_head_o    = '0;
    retired_budget_o = '0;
    late_resp_o      = 1'b0;
    if (w_pop) begin
      ld_free_we_o     = 1'b1;
      ld_free_idx_o    = r_head;
      ht_we_o          = 1'b1;
      ht_idx_o         = r_ht_idx;
      ht_release_o     = (r_head == r_tail);
      ht_new_head_o    = (r_head == r_tail) ? '0 : r_next;
      retired_budget_o = r_counter;
      late_resp_o      = (r_counter == '0);
    end
  end

  assign unexpected_resp_o = r_unexpected;
  assign overrun_o         = r_overrun;
  assign outstanding_o     = r_outstanding;

  // Lookup capture and status registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id          <= '0;
      r_ht_idx      <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_next        <= '0;
      r_counter     <= '0;
      r_unexpected  <= 1'b0;
      r_overrun     <= 1'b0;
      r_outstanding <= '0;
    end else begin
      if (r_state == S_IDLE && w_hs) r_id <= b_id_i;

      if (r_state == S_LOOKUP && w_hit) begin
        r_ht_idx  <= w_hit_idx;
        r_head    <= w_hit_head;
        r_tail    <= w_hit_tail;
        r_next    <= ld_next_i[int'(w_hit_head)*LD_IDX_W +: LD_IDX_W];
        r_counter <= ld_counter_i[int'(w_hit_head)*CNT_WIDTH +: CNT_WIDTH];
      end

      r_unexpected <= (r_state == S_LOOKUP) && !w_hit;

      // A response arriving while busy is dropped; retiring with nothing
      // outstanding means the bookkeeping has diverged. Both are sticky.
      if ((w_hs && r_state != S_IDLE) || (w_pop && r_outstanding == '0))
        r_overrun <= 1'b1;

      case ({enq_done_i, w_pop})
        2'b10: if (r_outstanding != c_out_max) r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01: if (r_outstanding != '0)        r_outstanding <= r_outstanding - OUT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_txn_dequeue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_txn_dequeue                                               |
// | Description : Directed self-checking bench for txn_dequeue.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_txn_dequeue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        b_valid = 1'b0;
  logic        b_ready = 1'b1;
  logic [3:0]  b_id = '0;
  logic        enq_done = 1'b0;
  logic [31:0] ht_id = '0;
  logic [23:0] ht_head = '0;
  logic [23:0] ht_tail = '0;
  logic [7:0]  ht_free = '1;
  logic [23:0] ld_next = '0;
  logic [79:0] ld_counter = '0;

  logic        b_stall, enq_inhibit, ld_free_we, ht_we, ht_release;
  logic        late_resp, unexpected_resp, overrun;
  logic [2:0]  ld_free_idx, ht_idx, ht_new_head;
  logic [9:0]  retired_budget;
  logic [3:0]  outstanding;

  int n_checks = 0;
  int n_fail   = 0;

  // {ld_free_we, ld_free_idx, ht_we, ht_idx, release, new_head, budget, late, unexpected}
  logic [23:0] pop_obs;
  assign pop_obs = {ld_free_we, ld_free_idx, ht_we, ht_idx, ht_release, ht_new_head,
                    retired_budget, late_resp, unexpected_resp};

  txn_dequeue dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .b_valid_i         (b_valid),
    .b_ready_i         (b_ready),
    .b_id_i            (b_id),
    .enq_done_i        (enq_done),
    .ht_id_i           (ht_id),
    .ht_head_i         (ht_head),
    .ht_tail_i         (ht_tail),
    .ht_free_i         (ht_free),
    .ld_next_i         (ld_next),
    .ld_counter_i      (ld_counter),
    .b_stall_o         (b_stall),
    .enq_inhibit_o     (enq_inhibit),
    .ld_free_we_o      (ld_free_we),
    .ld_free_idx_o     (ld_free_idx),
    .ht_we_o           (ht_we),
    .ht_idx_o          (ht_idx),
    .ht_release_o      (ht_release),
    .ht_new_head_o     (ht_new_head),
    .retired_budget_o  (retired_budget),
    .late_resp_o       (late_resp),
    .unexpected_resp_o (unexpected_resp),
    .overrun_o         (overrun),
    .outstanding_o     (outstanding)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_table();
    ht_id = '0; ht_head = '0; ht_tail = '0; ht_free = '1;
    ld_next = '0; ld_counter = '0;
  endtask

  task automatic set_ht(input int k, input logic [3:0] id, input logic [2:0] head,
                        input logic [2:0] tail);
    ht_id[k*4 +: 4]   = id;
    ht_head[k*3 +: 3] = head;
    ht_tail[k*3 +: 3] = tail;
    ht_free[k]        = 1'b0;
  endtask

  task automatic set_ld(input int s, input logic [2:0] nxt, input logic [9:0] cnt);
    ld_next[s*3 +: 3]     = nxt;
    ld_counter[s*10 +: 10] = cnt;
  endtask

  task automatic enq(input int n);
    enq_done = 1'b1;
    repeat (n) tick();
    enq_done = 1'b0;
  endtask

  // Handshake in one cycle; returns in the LOOKUP cycle.
  task automatic b_hs(input logic [3:0] id);
    b_valid = 1'b1;
    b_id    = id;
    tick();
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (pop_obs !== 24'd0) begin
      n_fail++; $display("FAIL reset_strobes: got %h expected %h", pop_obs, 24'd0);
    end
    n_checks++;
    if ({b_stall, enq_inhibit, overrun, outstanding} !== 7'd0) begin
      n_fail++; $display("FAIL reset_status: got %b expected %b",
                         {b_stall, enq_inhibit, overrun, outstanding}, 7'd0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    clear_table();
    set_ht(5, 4'd3, 3'd2, 3'd2);
    set_ld(2, 3'd0, 10'd5);
    enq(1);
    b_hs(4'd3);
    n_checks++;
    if ({b_stall, enq_inhibit} !== 2'b11) begin
      n_fail++; $display("FAIL single_stall: got %b expected 11", {b_stall, enq_inhibit});
    end
    tick();
    n_checks++;
    if (pop_obs !== {1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 3'd0, 10'd5, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_pop: got %h expected %h", pop_obs,
                         {1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 3'd0, 10'd5, 1'b0, 1'b0});
    end
    tick();
    n_checks++;
    if ({b_stall, outstanding} !== 5'd0) begin
      n_fail++; $display("FAIL single_after: got %b expected %b", {b_stall, outstanding}, 5'd0);
    end
  endtask

  task automatic test_two_writes();
    clear_table();
    ht_id[3:0] = 4'd1;               // free decoy with the same ID
    set_ht(2, 4'd1, 3'd0, 3'd4);
    set_ld(0, 3'd4, 10'd7);
    set_ld(4, 3'd0, 10'd3);
    enq(2);
    b_hs(4'd1);
    tick();
    n_checks++;
    if (pop_obs !== {1'b1, 3'd0, 1'b1, 3'd2, 1'b0, 3'd4, 10'd7, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL two_pop1: got %h expected %h", pop_obs,
                         {1'b1, 3'd0, 1'b1, 3'd2, 1'b0, 3'd4, 10'd7, 1'b0, 1'b0});
    end
    tick();
    n_checks++;
    if (outstanding !== 4'd1) begin
      n_fail++; $display("FAIL two_out1: got %0d expected 1", outstanding);
    end
    set_ht(2, 4'd1, 3'd4, 3'd4);
    b_hs(4'd1);
    tick();
    n_checks++;
    if (pop_obs !== {1'b1, 3'd4, 1'b1, 3'd2, 1'b1, 3'd0, 10'd3, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL two_pop2: got %h expected %h", pop_obs,
                         {1'b1, 3'd4, 1'b1, 3'd2, 1'b1, 3'd0, 10'd3, 1'b0, 1'b0});
    end
    tick();
    n_checks++;
    if (outstanding !== 4'd0) begin
      n_fail++; $display("FAIL two_out2: got %0d expected 0", outstanding);
    end
  endtask

  task automatic test_unexpected();
    clear_table();
    ht_id[3:0] = 4'd7;               // ID matches but entry is free
    set_ht(4, 4'd2, 3'd1, 3'd1);
    enq(1);
    b_hs(4'd7);
    tick();
    n_checks++;
    if (pop_obs !== 24'd1) begin
      n_fail++; $display("FAIL unexp_pulse: got %h expected %h", pop_obs, 24'd1);
    end
    tick();
    n_checks++;
    if (pop_obs !== 24'd0) begin
      n_fail++; $display("FAIL unexp_end: got %h expected %h", pop_obs, 24'd0);
    end
    n_checks++;
    if (outstanding !== 4'd1) begin
      n_fail++; $display("FAIL unexp_out: got %0d expected 1", outstanding);
    end
  endtask

  task automatic test_late();
    clear_table();
    set_ht(7, 4'd5, 3'd1, 3'd1);
    set_ld(1, 3'd0, 10'd0);
    b_hs(4'd5);
    tick();
    n_checks++;
    if (pop_obs !== {1'b1, 3'd1, 1'b1, 3'd7, 1'b1, 3'd0, 10'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL late_pop: got %h expected %h", pop_obs,
                         {1'b1, 3'd1, 1'b1, 3'd7, 1'b1, 3'd0, 10'd0, 1'b1, 1'b0});
    end
    tick();
    n_checks++;
    if ({overrun, outstanding} !== 5'd0) begin
      n_fail++; $display("FAIL late_after: got %b expected %b", {overrun, outstanding}, 5'd0);
    end
  endtask

  task automatic test_back_to_back();
    clear_table();
    set_ht(1, 4'd6, 3'd3, 3'd3);
    set_ld(3, 3'd0, 10'd9);
    enq(1);
    b_valid = 1'b1;
    b_id    = 4'd6;
    tick(); tick();                  // second handshake lands in LOOKUP
    b_valid = 1'b0;
    n_checks++;
    if (pop_obs !== {1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd0, 10'd9, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL b2b_pop: got %h expected %h", pop_obs,
                         {1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd0, 10'd9, 1'b0, 1'b0});
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL b2b_overrun: got %b expected 1", overrun);
    end
    tick(); tick(); tick();
    n_checks++;
    if ({pop_obs, b_stall, outstanding} !== 29'd0) begin
      n_fail++; $display("FAIL b2b_single_retire: got %h expected 0",
                         {pop_obs, b_stall, outstanding});
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL b2b_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_enq_with_pop();
    clear_table();
    set_ht(3, 4'd2, 3'd6, 3'd6);
    set_ld(6, 3'd0, 10'd4);
    enq(3);
    n_checks++;
    if (outstanding !== 4'd3) begin
      n_fail++; $display("FAIL enqpop_pre: got %0d expected 3", outstanding);
    end
    b_hs(4'd2);
    tick();
    enq_done = 1'b1;                 // coincides with the POP cycle
    tick();
    enq_done = 1'b0;
    n_checks++;
    if (outstanding !== 4'd3) begin
      n_fail++; $display("FAIL enqpop_hold: got %0d expected 3", outstanding);
    end
  endtask

  task automatic test_saturation();
    enq(6);
    n_checks++;
    if (outstanding !== 4'd8) begin
      n_fail++; $display("FAIL sat_max: got %0d expected 8", outstanding);
    end
  endtask

  task automatic test_reset_in_lookup();
    clear_table();
    set_ht(0, 4'd9, 3'd5, 3'd5);
    set_ld(5, 3'd0, 10'd2);
    b_hs(4'd9);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({pop_obs, b_stall, enq_inhibit, overrun, outstanding} !== 31'd0) begin
      n_fail++; $display("FAIL rst_lookup_async: got %h expected 0",
                         {pop_obs, b_stall, enq_inhibit, overrun, outstanding});
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({pop_obs, b_stall} !== 25'd0) begin
      n_fail++; $display("FAIL rst_lookup_nostrobe: got %h expected 0", {pop_obs, b_stall});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_two_writes();
    test_unexpected();
    test_late();
    test_back_to_back();
    test_enq_with_pop();
    test_saturation();
    test_reset_in_lookup();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
